// File: rtl/pb_conditioner_if.sv
// Bus between the pushbutton conditioner (slave) and the processor/board side (master).
// The release pulse is named release_pulse because "release" is a reserved word.
interface pb_conditioner_if;
  logic [3:0] btn_raw;
  logic       rd_ack;
  logic [3:0] pushbuttons;
  logic [3:0] db_level;
  logic [3:0] press;
  logic [3:0] release_pulse;
  logic       any_latched;

  modport master (
    output btn_raw,
    output rd_ack,
    input  pushbuttons,
    input  db_level,
    input  press,
    input  release_pulse,
    input  any_latched
  );

  modport slave (
    input  btn_raw,
    input  rd_ack,
    output pushbuttons,
    output db_level,
    output press,
    output release_pulse,
    output any_latched
  );
endinterface

// File: rtl/pb_conditioner.sv
// Four-channel pushbutton synchroniser, debouncer and press latch.
// Each channel feeds the processor's pushbuttons port with either its debounced level or its press latch.
module pb_conditioner #(
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit STICKY          = 1'b0
) (
  input logic             clk,
  input logic             reset,
  pb_conditioner_if.slave pb
);

  localparam longint MAX_LEGAL = (64'sd1 <<< CNT_W) - 64'sd1;

  generate
    if (DEBOUNCE_CYCLES < 1 || longint'(DEBOUNCE_CYCLES) > MAX_LEGAL) begin : g_bad_cfg
      $error("pb_conditioner: DEBOUNCE_CYCLES must be within 1 .. 2**CNT_W-1");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0] lat_all;

  assign pb.any_latched = |lat_all;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ch
      logic             s1_q, s1_d;
      logic             s2_q, s2_d;
      logic             db_q, db_d;
      logic             press_q, press_d;
      logic             rel_q, rel_d;
      logic             lat_q, lat_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;

      always_comb begin
        s1_d    = pb.btn_raw[gi];
        s2_d    = s1_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        // Any sample matching the accepted level throws away the partial count.
        if (s2_q == db_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          db_d    = s2_q;
          cnt_d   = '0;
          press_d = s2_q;
          rel_d   = ~s2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        // A press landing on the same edge as a read survives the clear.
        lat_d = press_d | (lat_q & ~pb.rd_ack);
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s1_q    <= 1'b0;
          s2_q    <= 1'b0;
          db_q    <= 1'b0;
          press_q <= 1'b0;
          rel_q   <= 1'b0;
          lat_q   <= 1'b0;
          cnt_q   <= '0;
        end else begin
          s1_q    <= s1_d;
          s2_q    <= s2_d;
          db_q    <= db_d;
          press_q <= press_d;
          rel_q   <= rel_d;
          lat_q   <= lat_d;
          cnt_q   <= cnt_d;
        end
      end

      assign pb.db_level[gi]      = db_q;
      assign pb.press[gi]         = press_q;
      assign pb.release_pulse[gi] = rel_q;
      assign pb.pushbuttons[gi]   = STICKY ? lat_q : db_q;
      assign lat_all[gi]          = lat_q;
    end
  endgenerate

endmodule

// File: tb/tb_pb_conditioner.sv
// Bench for pb_conditioner: directed vector table, corner sequences and a random run against a window-based model.
module tb_pb_conditioner;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic       rd;

  int checks = 0;
  int errors = 0;

  pb_conditioner_if if0 ();
  pb_conditioner_if if1 ();

  assign if0.btn_raw = btn;
  assign if0.rd_ack  = rd;
  assign if1.btn_raw = btn;
  assign if1.rd_ack  = rd;

  pb_conditioner #(.CNT_W(3), .DEBOUNCE_CYCLES(N), .STICKY(1'b0)) u_plain (
    .clk(clk), .reset(rst), .pb(if0.slave));
  pb_conditioner #(.CNT_W(3), .DEBOUNCE_CYCLES(N), .STICKY(1'b1)) u_sticky (
    .clk(clk), .reset(rst), .pb(if1.slave));

  always #5 clk = ~clk;

  // Reference model: a level is accepted once the last N synchronised samples all differ from it.
  logic [3:0] raw_q[$];
  logic [3:0] samp_q[$];
  logic [3:0] db_m, pr_m, rl_m, lat_m;

  task automatic model_reset();
    raw_q.delete();
    samp_q.delete();
    db_m = 4'h0; pr_m = 4'h0; rl_m = 4'h0; lat_m = 4'h0;
  endtask

  task automatic model_step();
    logic [3:0] s;
    bit all_diff;
    raw_q.push_back(btn);
    if (raw_q.size() > 3) void'(raw_q.pop_front());
    s = (raw_q.size() == 3) ? raw_q[0] : 4'h0;
    samp_q.push_back(s);
    if (samp_q.size() > N) void'(samp_q.pop_front());
    pr_m = 4'h0;
    rl_m = 4'h0;
    if (samp_q.size() == N) begin
      for (int i = 0; i < 4; i++) begin
        all_diff = 1'b1;
        for (int k = 0; k < N; k++)
          if (samp_q[k][i] == db_m[i]) all_diff = 1'b0;
        if (all_diff) begin
          db_m[i] = ~db_m[i];
          if (db_m[i]) pr_m[i] = 1'b1;
          else         rl_m[i] = 1'b1;
        end
      end
    end
    lat_m = pr_m | (lat_m & ~{4{rd}});
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("m_db_plain",   if0.db_level,          db_m);
    chk("m_db_sticky",  if1.db_level,          db_m);
    chk("m_press",      if0.press,             pr_m);
    chk("m_release",    if0.release_pulse,     rl_m);
    chk("m_press_s",    if1.press,             pr_m);
    chk("m_release_s",  if1.release_pulse,     rl_m);
    chk("m_pb_plain",   if0.pushbuttons,       db_m);
    chk("m_pb_sticky",  if1.pushbuttons,       lat_m);
    chk("m_any_plain",  {3'b0, if0.any_latched}, {3'b0, |lat_m});
    chk("m_any_sticky", {3'b0, if1.any_latched}, {3'b0, |lat_m});
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    @(negedge clk);
    compare_model();
  endtask

  typedef struct packed {
    logic [3:0] btn;
    logic       rd;
    logic [3:0] db;
    logic [3:0] pr;
    logic [3:0] rl;
    logic [3:0] lat;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int rise, rise0, rise3, np;

    // Row r drives inputs before edge r+1 after reset release; expectations hold after that edge.
    for (int r = 0; r < 5; r++) tbl[r] = '{4'hF, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[5]  = '{4'hF, 1'b0, 4'hF, 4'hF, 4'h0, 4'hF};
    for (int r = 6; r < 11; r++) tbl[r] = '{4'h0, 1'b0, 4'hF, 4'h0, 4'h0, 4'hF};
    tbl[11] = '{4'h0, 1'b0, 4'h0, 4'h0, 4'hF, 4'hF};
    tbl[12] = '{4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[13] = '{4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0};

    model_reset();
    rst = 1'b1; btn = 4'hF; rd = 1'b0;
    repeat (3) cycle();
    chk("rst_db",     if0.db_level,      4'h0);
    chk("rst_press",  if0.press,         4'h0);
    chk("rst_rel",    if0.release_pulse, 4'h0);
    chk("rst_pb_s",   if1.pushbuttons,   4'h0);
    chk("rst_any_s",  {3'b0, if1.any_latched}, 4'h0);
    rst = 1'b0;

    // Reset release with buttons held, then release all, then a read that clears the latch.
    for (int r = 0; r < 14; r++) begin
      btn = tbl[r].btn;
      rd  = tbl[r].rd;
      cycle();
      chk($sformatf("tbl%0d_db", r),    if0.db_level,      tbl[r].db);
      chk($sformatf("tbl%0d_press", r), if0.press,         tbl[r].pr);
      chk($sformatf("tbl%0d_rel", r),   if0.release_pulse, tbl[r].rl);
      chk($sformatf("tbl%0d_pb_s", r),  if1.pushbuttons,   tbl[r].lat);
      chk($sformatf("tbl%0d_any_s", r), {3'b0, if1.any_latched}, {3'b0, |tbl[r].lat});
    end
    rd = 1'b0;

    // Bounce on channel 2: high 3, low 1, then held; acceptance 5 edges after the last rise.
    rise = 0; np = 0;
    for (int i = 0; i < 15; i++) begin
      btn = (i < 3) ? 4'h4 : (i == 3) ? 4'h0 : 4'h4;
      cycle();
      if (if0.press[2]) np++;
      if (if0.db_level[2] && rise == 0) rise = i + 1;
    end
    chk("bounce_rise_edge", 4'(rise), 4'd10);
    chk("bounce_press_cnt", 4'(np),   4'd1);
    btn = 4'h0;
    repeat (8) cycle();

    // Read on the same edge as press[3] is generated: the latch must survive.
    for (int i = 0; i < 10; i++) begin
      btn = 4'h8;
      rd  = (i == 5 || i == 7);
      cycle();
      if (i == 5) begin
        chk("sbc_press3", if1.press,       4'h8);
        chk("sbc_pb",     if1.pushbuttons, 4'h8);
      end
      if (i == 6) chk("sbc_pb_hold", if1.pushbuttons, 4'h8);
      if (i == 7) begin
        chk("sbc_pb_clr",  if1.pushbuttons, 4'h0);
        chk("sbc_any_clr", {3'b0, if1.any_latched}, 4'h0);
      end
    end
    rd = 1'b0; btn = 4'h0;
    repeat (8) cycle();

    // Channels 0 and 3 offset by two cycles are accepted two edges apart.
    rise0 = 0; rise3 = 0;
    for (int i = 0; i < 12; i++) begin
      btn = {(i >= 2), 2'b00, 1'b1};
      cycle();
      if (if0.db_level[0] && rise0 == 0) rise0 = i + 1;
      if (if0.db_level[3] && rise3 == 0) rise3 = i + 1;
    end
    chk("indep_rise0", 4'(rise0), 4'd6);
    chk("indep_rise3", 4'(rise3), 4'd8);
    btn = 4'h0;
    repeat (8) cycle();

    // Random buttons, reads and occasional asynchronous resets against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        compare_model();
        repeat (2) cycle();
        rst = 1'b0;
      end
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 5) == 0) btn[i] = ~btn[i];
      rd = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
